window_col_streamer: RTL and testbench

//  Parametrised line-buffered window-column generator for the edge-detection chain.

---
 rtl/window_col_streamer.sv | 162 ++++++++++++++++
 tb/tb_window_col_streamer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/window_col_streamer.sv
// rtl/window_col_streamer.sv - line-buffered KxK window column generator with replicated borders
module window_col_streamer #(
    parameter int IMG_W      = 20,
    parameter int IMG_H      = 20,
    parameter int BIT_LENGTH = 5,
    parameter int KMAX       = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ksize_sel,
    input  logic [BIT_LENGTH-1:0]      pixel_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [KMAX*BIT_LENGTH-1:0] col_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sol,
    output logic                       out_eol,
    output logic                       out_last,
    output logic                       frame_done
);
    localparam int CW = $clog2(IMG_W + 4);
    localparam int RW = $clog2(IMG_H + 4);
    localparam int SW = $clog2(KMAX);
    localparam int XW = $clog2(IMG_W);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;
    state_t state;

    logic [BIT_LENGTH-1:0] ring [KMAX][IMG_W];
    logic [CW-1:0] in_col;
    logic [CW-1:0] ecol;
    logic [RW-1:0] in_row;
    logic [RW-1:0] out_row;
    logic [SW-1:0] in_slot;
    logic          k5;
    logic          issued;
    logic [1:0]    rad;
    logic [1:0]    rad_new;
    logic [1:0]    rad_n;
    logic          accept;
    logic          out_load;
    logic          out_fire;
    logic          last_col;
    logic [KMAX*BIT_LENGTH-1:0] beat;
    int            y;
    int            x;

    assign rad      = (KMAX >= 5 && k5) ? 2'd2 : 2'd1;
    assign rad_new  = (KMAX >= 5 && ksize_sel) ? 2'd2 : 2'd1;
    // The radius for the first row's completion decision comes straight from ksize_sel in IDLE.
    assign rad_n    = (state == IDLE) ? rad_new : rad;
    assign accept   = in_ready && in_valid;
    assign out_load = !out_valid || out_ready;
    assign out_fire = out_valid && out_ready;
    assign last_col = (int'(ecol) == IMG_W + 2 * int'(rad) - 1);

    always_comb begin
        beat = '0;
        y    = 0;
        x    = 0;
        for (int j = 0; j < KMAX; j++) begin
            if (j < 2 * int'(rad) + 1) begin
                y = int'(out_row) - int'(rad) + j;
                if (y < 0) y = 0;
                if (y > IMG_H - 1) y = IMG_H - 1;
                x = int'(ecol) - int'(rad);
                if (x < 0) x = 0;
                if (x > IMG_W - 1) x = IMG_W - 1;
                beat[j*BIT_LENGTH +: BIT_LENGTH] = ring[SW'(y % KMAX)][XW'(x)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ring[in_slot][XW'(in_col)] <= pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            col_out    <= '0;
            out_sol    <= 1'b0;
            out_eol    <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            in_col     <= '0;
            ecol       <= '0;
            in_row     <= '0;
            out_row    <= '0;
            in_slot    <= '0;
            k5         <= 1'b0;
            issued     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_fire) out_valid <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (state == IDLE) k5 <= (KMAX >= 5) && ksize_sel;
                        if (in_col == CW'(IMG_W - 1)) begin
                            in_col  <= '0;
                            in_slot <= (in_slot == SW'(KMAX - 1)) ? '0 : in_slot + 1'b1;
                            if (in_row < RW'(rad_n)) begin
                                in_row <= in_row + 1'b1;
                                state  <= LOAD;
                            end else begin
                                state    <= EMIT;
                                in_ready <= 1'b0;
                                out_row  <= in_row - RW'(rad_n);
                                ecol     <= '0;
                                issued   <= 1'b0;
                            end
                        end else begin
                            in_col <= in_col + 1'b1;
                            state  <= LOAD;
                        end
                    end
                end
                EMIT: begin
                    if (out_load && !issued) begin
                        out_valid <= 1'b1;
                        col_out   <= beat;
                        out_sol   <= (ecol == '0);
                        out_eol   <= last_col;
                        out_last  <= last_col && (out_row == RW'(IMG_H - 1));
                        ecol      <= ecol + 1'b1;
                        if (last_col) issued <= 1'b1;
                    end else if (issued && out_fire) begin
                        issued <= 1'b0;
                        ecol   <= '0;
                        if (out_row == RW'(IMG_H - 1)) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else if (int'(out_row) + 1 + int'(rad) <= IMG_H - 1) begin
                            // Next input row lands in the oldest slot, no longer referenced.
                            state    <= LOAD;
                            in_ready <= 1'b1;
                            in_row   <= in_row + 1'b1;
                            out_row  <= out_row + 1'b1;
                        end else begin
                            out_row <= out_row + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    in_row   <= '0;
                    in_col   <= '0;
                    in_slot  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_window_col_streamer.sv
// tb/tb_window_col_streamer.sv - scoreboard bench for window_col_streamer
module tb_window_col_streamer;
    localparam int W  = 20;
    localparam int H  = 20;
    localparam int BL = 5;
    localparam int KM = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ksize_sel = 1'b0;
    logic [BL-1:0] pixel_in = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [KM*BL-1:0] col_out;
    logic out_valid;
    logic out_ready = 1'b1;
    logic out_sol, out_eol, out_last, frame_done;

    window_col_streamer #(.IMG_W(W), .IMG_H(H), .BIT_LENGTH(BL), .KMAX(KM)) dut (
        .clk(clk), .reset(reset), .ksize_sel(ksize_sel), .pixel_in(pixel_in),
        .in_valid(in_valid), .in_ready(in_ready), .col_out(col_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_sol(out_sol),
        .out_eol(out_eol), .out_last(out_last), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [KM*BL-1:0] col;
        logic             sol;
        logic             eol;
        logic             last;
    } beat_t;

    beat_t exp_q[$];
    int vectors = 0;
    int errors = 0;
    int beats = 0;
    int fd_seen = 0;
    bit rand_ready = 1'b0;
    bit abort = 1'b0;
    bit fd_expect = 1'b0;
    bit prev_stall = 1'b0;
    bit sender_busy = 1'b0;
    beat_t prev;
    logic [KM*BL-1:0] first_col;
    logic [KM*BL-1:0] final_col;
    int acc_t5;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic push_frame(input int k);
        int r;
        beat_t b;
        r = (k - 1) / 2;
        for (int orow = 0; orow < H; orow++) begin
            for (int e = 0; e < W + 2 * r; e++) begin
                int c;
                c = clampi(e - r, W - 1);
                b = '0;
                for (int j = 0; j < k; j++) begin
                    int yy;
                    yy = clampi(orow - r + j, H - 1);
                    b.col[j*BL +: BL] = BL'((yy + c) % 32);
                end
                b.sol  = (e == 0);
                b.eol  = (e == W + 2 * r - 1);
                b.last = b.eol && (orow == H - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                fd_expect  = 1'b0;
            end else begin
                check("frame_done", {63'd0, frame_done}, {63'd0, fd_expect});
                if (frame_done === 1'b1) fd_seen++;
                fd_expect = 1'b0;
                if (out_valid === 1'b1) check("in_ready_in_emit", {63'd0, in_ready}, 64'd0);
                if (prev_stall) check("stall_hold", 64'({col_out, out_sol, out_eol, out_last}), 64'(prev));
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (beats == 0) first_col = col_out;
                    if (out_last === 1'b1) begin
                        final_col = col_out;
                        fd_expect = 1'b1;
                    end
                    beats++;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $error("FAIL extra_beat: observed %0h expected none", col_out);
                    end else begin
                        check("beat", 64'({col_out, out_sol, out_eol, out_last}), 64'(exp_q.pop_front()));
                    end
                end
                prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
                prev = {col_out, out_sol, out_eol, out_last};
            end
        end
    end

    task automatic send_frame(input int gap, input int toggle_at, output int acc);
        sender_busy = 1'b1;
        acc = 0;
        for (int r = 0; r < H && !abort; r++) begin
            for (int c = 0; c < W && !abort; c++) begin
                bit ok;
                int t;
                ok = 1'b0;
                t = 0;
                in_valid = 1'b1;
                pixel_in = BL'((r + c) % 32);
                while (!ok && !abort) begin
                    @(negedge clk);
                    ok = (in_ready === 1'b1);
                    @(posedge clk);
                    #1;
                    t++;
                    if (!ok && t > 5000) begin
                        vectors++;
                        errors++;
                        $error("FAIL in_timeout: observed no in_ready expected acceptance");
                        abort = 1'b1;
                    end
                end
                if (ok) begin
                    acc++;
                    if (acc == toggle_at) ksize_sel = ~ksize_sel;
                    if (gap > 0) begin
                        in_valid = 1'b0;
                        repeat (gap) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
            end
        end
        in_valid = 1'b0;
        sender_busy = 1'b0;
    endtask

    task automatic run_frame(input int k, input int gap, input int toggle_at, input bit rr);
        int acc;
        int to;
        int fd0;
        logic [KM*BL-1:0] exp_first;
        logic [KM*BL-1:0] exp_final;
        exp_first = (k == 5) ? {5'd2, 5'd1, 5'd0, 5'd0, 5'd0} : {5'd0, 5'd0, 5'd1, 5'd0, 5'd0};
        exp_final = (k == 5) ? {5'd6, 5'd6, 5'd6, 5'd5, 5'd4} : {5'd0, 5'd0, 5'd6, 5'd6, 5'd5};
        push_frame(k);
        beats = 0;
        fd0 = fd_seen;
        ksize_sel = (k == 5);
        rand_ready = rr;
        send_frame(gap, toggle_at, acc);
        check("accepted", 64'(acc), 64'(W * H));
        to = 0;
        while (fd_seen == fd0 && to < 20000) begin
            @(negedge clk);
            to++;
        end
        check("frame_done_count", 64'(fd_seen), 64'(fd0 + 1));
        check("beat_count", 64'(beats), 64'(H * (W + k - 1)));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("first_beat", 64'(first_col), 64'(exp_first));
        check("final_beat", 64'(final_col), 64'(exp_final));
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int to;
        int fd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_col_out", 64'(col_out), 64'd0);
        check("rst_flags", {60'd0, out_sol, out_eol, out_last, frame_done}, 64'd0);
        reset = 1'b0;

        run_frame(3, 0, -1, 1'b0);
        run_frame(5, 0, -1, 1'b0);
        run_frame(3, 0, -1, 1'b1);
        run_frame(3, 0, 37, 1'b0);
        run_frame(5, 0, -1, 1'b0);

        push_frame(3);
        beats = 0;
        ksize_sel = 1'b0;
        fd0 = fd_seen;
        fork
            send_frame(0, -1, acc_t5);
        join_none
        #1;
        to = 0;
        while (beats < 7 * 22 + 5 && to < 20000) begin
            @(negedge clk);
            to++;
        end
        check("t5_reached_row7", 64'(beats >= 7 * 22 + 5), 64'd1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_out_valid", {63'd0, out_valid}, 64'd0);
        check("t5_frame_done", {63'd0, frame_done}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        to = 0;
        while (sender_busy && to < 100) begin
            @(posedge clk);
            to++;
        end
        #1;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5_in_ready_idle", {63'd0, in_ready}, 64'd1);
        check("t5_no_frame_done", 64'(fd_seen), 64'(fd0));
        run_frame(3, 0, -1, 1'b0);

        run_frame(3, 2, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
